vga_timing_ctrl: RTL

- Generates VGA raster timing (default 640x480@60 on a 25 MHz pixel clock).
- Drives the pixel coordinate and request outputs consumed by the pattern/image/display pixel logic.
- Samples the 4-bit RGB that logic returns, then emits registered, blank-gated colour with aligned HS/VS to the DAC pins.
- Also provides frame and line strobes for game-state update logic (slider, ball, block flags).

---
 rtl/vga_timing_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/vga_timing_ctrl.sv
// -----------------------------------------------------------------------------
// vga_timing_ctrl
//
// VGA raster timing generator with a one-stage colour/sync output pipeline.
// Default timing is 640x480@60 on a 25 MHz pixel clock.
//
// Stage 0 (combinational from the counters):
//   oVGA_X, oVGA_Y, oRequest -> coordinate and request for the pixel logic.
// Stage 1 (registered every clock):
//   oVGA_R/G/B    colour returned by the pixel logic, forced to 0 in blanking
//   oVGA_HS/VS    sync, delayed one clock so it lines up with colour
//   oVGA_BLANK    1 during the blanking interval
//   oLine_tick    one-cycle pulse after the last clock of every line
//   oFrame_tick   one-cycle pulse after the last visible pixel of a frame
//
// Ports:
//   iVGA_CLK             pixel clock
//   iRST                 asynchronous, active-high reset
//   iRed/iGreen/iBlue    4-bit colour for the coordinate shown this cycle
//   oVGA_X/oVGA_Y        10-bit visible coordinate (0 outside active area)
//   oRequest             1 when the coordinate is a visible pixel
//   oVGA_R/G/B           4-bit registered colour to the DAC
//   oVGA_HS/oVGA_VS      registered syncs, pulse level set by SYNC_POL
//   oVGA_BLANK           registered blanking flag
//   oFrame_tick          registered frame strobe
//   oLine_tick           registered line strobe
//
// Both totals must be at most 1024 because the counters are 10 bits wide.
// -----------------------------------------------------------------------------
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       iVGA_CLK,
  input  logic       iRST,
  input  logic [3:0] iRed,
  input  logic [3:0] iGreen,
  input  logic [3:0] iBlue,
  output logic [9:0] oVGA_X,
  output logic [9:0] oVGA_Y,
  output logic       oRequest,
  output logic [3:0] oVGA_R,
  output logic [3:0] oVGA_G,
  output logic [3:0] oVGA_B,
  output logic       oVGA_HS,
  output logic       oVGA_VS,
  output logic       oVGA_BLANK,
  output logic       oFrame_tick,
  output logic       oLine_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 10-bit versions of the segment boundaries so every compare is width-matched.
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_LASTA = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_LASTA = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       active;
  logic       h_sync_on;
  logic       v_sync_on;
  logic       line_end;
  logic       frame_end;

  // Raster counters: v_cnt only moves on the last clock of a line, so a
  // frame wrap and a line wrap land on the same edge.
  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      h_cnt <= 10'd0;
      v_cnt <= 10'd0;
    end else if (line_end) begin
      h_cnt <= 10'd0;
      if (v_cnt == V_LAST) begin
        v_cnt <= 10'd0;
      end else begin
        v_cnt <= v_cnt + 10'd1;
      end
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  always_comb begin
    active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    h_sync_on = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    v_sync_on = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    line_end  = (h_cnt == H_LAST);
    frame_end = (h_cnt == H_LASTA) && (v_cnt == V_LASTA);
  end

  // Stage 0: coordinate handed to the pixel logic this cycle.
  assign oVGA_X   = active ? h_cnt : 10'd0;
  assign oVGA_Y   = active ? v_cnt : 10'd0;
  assign oRequest = active;

  // Stage 1: the pixel logic answers within the cycle, so its colour is
  // captured on the same edge as the sync/blank derived from the same
  // counter values, keeping everything at the pins aligned.
  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      oVGA_R      <= 4'd0;
      oVGA_G      <= 4'd0;
      oVGA_B      <= 4'd0;
      oVGA_HS     <= ~SYNC_POL;
      oVGA_VS     <= ~SYNC_POL;
      oVGA_BLANK  <= 1'b1;
      oLine_tick  <= 1'b0;
      oFrame_tick <= 1'b0;
    end else begin
      // Colour outside the visible window is forced to black.
      oVGA_R      <= active ? iRed   : 4'd0;
      oVGA_G      <= active ? iGreen : 4'd0;
      oVGA_B      <= active ? iBlue  : 4'd0;
      oVGA_HS     <= h_sync_on ? SYNC_POL : ~SYNC_POL;
      oVGA_VS     <= v_sync_on ? SYNC_POL : ~SYNC_POL;
      oVGA_BLANK  <= ~active;
      oLine_tick  <= line_end;
      // Fires as vertical blanking starts, giving the game logic the whole
      // blanking interval to update its state.
      oFrame_tick <= frame_end;
    end
  end

endmodule
